cle_obj_stat: RTL
=================

Name: cle_obj_stat

Overview:
- Downstream consumer of the component labeling engine (CLE).
- After CLE asserts finish, this block scans the 32x32 labeled image held in sram_1024x8, read-only.
- Per distinct nonzero label, it accumulates pixel area and bounding box, then streams one record per object over a valid/ready interface to the reporting stage.
- It owns the SRAM port only while busy; the top-level mux hands the port over on busy.

Parameters:
- MAX_OBJ, 8, number of object table entries (distinct labels tracked).
- IMG_W, 32, image width/height in pixels; address = row*IMG_W + col.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse (CLE finish rising edge); ignored while busy
- sram_q  input  8  SRAM read data, valid one cycle after address
- sram_a  output  10  SRAM address (registered)
- sram_wen  output  1  SRAM write enable, constant 1 (read only)
- busy  output  1  high from start acceptance until done
- obj_valid  output  1  object record valid
- obj_ready  input  1  consumer accepts record when valid&ready
- obj_label  output  8  object label value
- obj_area  output  11  pixel count, 1..1024
- obj_rmin/obj_rmax  output  5 each  min/max row
- obj_cmin/obj_cmax  output  5 each  min/max column
- obj_last  output  1  marks final record
- obj_count  output  4  number of table entries in use (0..MAX_OBJ)
- overflow  output  1  sticky: more than MAX_OBJ distinct labels seen this run
- done  output  1  one-cycle pulse at end of run

Behaviour:
- Reset values: every output 0 except sram_wen=1. Table entries are invalid. FSM is in IDLE.
- FSM states: IDLE, SCAN, DRAIN, OUT, FIN.
- IDLE -> SCAN on start. Clears the table, obj_count and overflow; busy=1.
- Start is sampled at edge E0. sram_a = k is driven after edge E0+k, for k = 0..1023 (1024 SCAN cycles).
- Data for address k is accumulated at edge E0+k+2. This is a two-stage pipeline: the address and its row/col are delayed one cycle alongside the read.
- SCAN -> DRAIN after issuing address 1023. DRAIN holds one cycle for the final datum, then moves to OUT.
- The first obj_valid is high after edge E0+1026.
- Accumulate rule, per datum with q != 0:
  - Compare q against all valid entries in parallel.
  - On a hit: area += 1; rmin = min, rmax = max, cmin = min, cmax = max.
  - On a miss with free entries: allocate the next entry in raster order of first appearance, with label=q, area=1, rmin=rmax=row, cmin=cmax=col; obj_count += 1.
  - On a miss with the table full: set overflow; drop the pixel.
  - q == 0 is background and is ignored.
- OUT:
  - Present entries 0..obj_count-1 in order. Record fields are stable while valid && !ready.
  - Advance on handshake. obj_last = 1 on the final entry.
  - After the final handshake, go to FIN.
  - If obj_count == 0, OUT goes straight to FIN with no obj_valid.
- FIN: done=1 for one cycle, busy=0, then IDLE. obj_count and overflow hold until the next start.
- A start during busy is ignored.
- Reset mid-run aborts immediately to reset values. No partial records remain.
- Area never overflows: 11 bits covers 1024.

Decomposition:
- Shared package cle_pkg holds:
  - IMG_W, ADDR_W=10, LABEL_W=8, AREA_W=11, COORD_W=5.
  - A typedef obj_rec_t {label, area, rmin, rmax, cmin, cmax}.
  - The FSM state enum.
- One sub-module, cle_obj_table: MAX_OBJ entries with parallel label match, allocate and update logic, and an indexed read port for OUT.
- The top level holds the FSM, address counter, pipeline register and stream output.

Test Plan:
- Empty image (all 0), start pulse -> no obj_valid; done after edge E0+1027; obj_count=0; overflow=0; sram_wen=1 throughout.
- Single label 0x05 filling rows 3..6, cols 10..20 -> one record: label 05, area 44, r 3..6, c 10..20, obj_last=1.
- Five labels with first appearances in raster order 0x11, 0x03, 0x2A, 0x07, 0x40; obj_ready held high -> five records in that order, areas matching the image, obj_count=5.
- Ten distinct single-pixel labels -> eight records (first eight by raster order), overflow=1, obj_count=8.
- Backpressure: obj_ready toggled 0/1 randomly -> record fields stable while stalled; no record dropped or duplicated.
- Reset asserted at scan address 500, then a fresh start -> outputs at reset values; the second run's results are correct and no state is left from the aborted run; a second start pulse during busy has no effect.

Source files
------------

// File: rtl/cle_pkg.sv
// Shared types and constants for the CLE object statistics block.
// The image geometry, field widths, record layout and FSM encoding all live here.
package cle_pkg;

  localparam int IMG_W   = 32;
  localparam int ADDR_W  = 10;
  localparam int LABEL_W = 8;
  localparam int AREA_W  = 11;
  localparam int COORD_W = 5;
  localparam int CNT_W   = 4;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_W - 1);

  typedef struct packed {
    logic [LABEL_W-1:0] label;
    logic [AREA_W-1:0]  area;
    logic [COORD_W-1:0] rmin;
    logic [COORD_W-1:0] rmax;
    logic [COORD_W-1:0] cmin;
    logic [COORD_W-1:0] cmax;
  } obj_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_OUT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/cle_obj_table.sv
// Object table: parallel label match, raster-order allocation, area and bounding-box update,
// plus an indexed combinational read port used while streaming records out.
module cle_obj_table
  import cle_pkg::*;
#(
  parameter int MAX_OBJ = 8,
  parameter int IDX_W   = $clog2(MAX_OBJ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               upd_en_i,
  input  logic [LABEL_W-1:0] upd_label_i,
  input  logic [COORD_W-1:0] upd_row_i,
  input  logic [COORD_W-1:0] upd_col_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output obj_rec_t           rd_rec_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               overflow_o
);

  obj_rec_t             ent_q [MAX_OBJ];
  logic [MAX_OBJ-1:0]   hit_vec;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q;
  logic                 active;
  logic                 any_hit;
  logic                 full;
  logic                 alloc;

  assign active  = upd_en_i && (upd_label_i != '0);
  assign any_hit = |hit_vec;
  assign full    = (cnt_q == CNT_W'(MAX_OBJ));
  assign alloc   = active && !any_hit && !full;

  // Entries below cnt_q are the valid ones, so no separate valid bits are kept.
  for (genvar gi = 0; gi < MAX_OBJ; gi++) begin : g_ent
    assign hit_vec[gi] = (CNT_W'(gi) < cnt_q) && (ent_q[gi].label == upd_label_i);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ent_q[gi] <= '0;
      end else if (clr_i) begin
        ent_q[gi] <= '0;
      end else if (active && hit_vec[gi]) begin
        ent_q[gi].area <= ent_q[gi].area + AREA_W'(1);
        ent_q[gi].rmin <= (upd_row_i < ent_q[gi].rmin) ? upd_row_i : ent_q[gi].rmin;
        ent_q[gi].rmax <= (upd_row_i > ent_q[gi].rmax) ? upd_row_i : ent_q[gi].rmax;
        ent_q[gi].cmin <= (upd_col_i < ent_q[gi].cmin) ? upd_col_i : ent_q[gi].cmin;
        ent_q[gi].cmax <= (upd_col_i > ent_q[gi].cmax) ? upd_col_i : ent_q[gi].cmax;
      end else if (alloc && (cnt_q == CNT_W'(gi))) begin
        ent_q[gi] <= '{label: upd_label_i, area: AREA_W'(1),
                       rmin: upd_row_i, rmax: upd_row_i,
                       cmin: upd_col_i, cmax: upd_col_i};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (alloc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (active && !any_hit && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign rd_rec_o   = ent_q[rd_idx_i];
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/cle_obj_stat.sv
// Scans the labeled image after CLE finishes and streams one area/bounding-box record
// per distinct label over valid/ready. Scan FSM, read pipeline and output registers live here.
module cle_obj_stat
  import cle_pkg::*;
#(
  parameter int MAX_OBJ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LABEL_W-1:0] sram_q,
  output logic [ADDR_W-1:0]  sram_a,
  output logic               sram_wen,
  output logic               busy,
  output logic               obj_valid,
  input  logic               obj_ready,
  output logic [LABEL_W-1:0] obj_label,
  output logic [AREA_W-1:0]  obj_area,
  output logic [COORD_W-1:0] obj_rmin,
  output logic [COORD_W-1:0] obj_rmax,
  output logic [COORD_W-1:0] obj_cmin,
  output logic [COORD_W-1:0] obj_cmax,
  output logic               obj_last,
  output logic [CNT_W-1:0]   obj_count,
  output logic               overflow,
  output logic               done
);

  localparam int IDX_W = $clog2(MAX_OBJ);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  pipe_a_q, pipe_a_d;
  logic               pipe_v_q, pipe_v_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  obj_rec_t           rec_q, rec_d;
  logic               tbl_clr;
  obj_rec_t           tbl_rec;
  logic [CNT_W-1:0]   tbl_cnt;
  logic               tbl_ovf;

  cle_obj_table #(.MAX_OBJ(MAX_OBJ), .IDX_W(IDX_W)) u_table (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (tbl_clr),
    .upd_en_i   (pipe_v_q),
    .upd_label_i(sram_q),
    .upd_row_i  (pipe_a_q[ADDR_W-1 -: COORD_W]),
    .upd_col_i  (pipe_a_q[COORD_W-1:0]),
    .rd_idx_i   (idx_q[IDX_W-1:0]),
    .rd_rec_o   (tbl_rec),
    .count_o    (tbl_cnt),
    .overflow_o (tbl_ovf)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    last_d   = last_q;
    idx_d    = idx_q;
    rec_d    = rec_q;
    tbl_clr  = 1'b0;
    // The address travels with the read so row/col line up with sram_q a cycle later.
    pipe_v_d = (state_q == ST_SCAN);
    pipe_a_d = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          addr_d  = '0;
          busy_d  = 1'b1;
          idx_d   = '0;
          tbl_clr = 1'b1;
        end
      end
      ST_SCAN: begin
        if (addr_q == ADDR_LAST) state_d = ST_DRAIN;
        else                     addr_d  = addr_q + ADDR_W'(1);
      end
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        if (!valid_q || obj_ready) begin
          if ((valid_q && last_q) || (!valid_q && tbl_cnt == '0)) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_FIN;
          end else begin
            rec_d   = tbl_rec;
            valid_d = 1'b1;
            last_d  = ((idx_q + CNT_W'(1)) == tbl_cnt);
            idx_d   = idx_q + CNT_W'(1);
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      pipe_a_q <= '0;
      pipe_v_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      idx_q    <= '0;
      rec_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pipe_a_q <= pipe_a_d;
      pipe_v_q <= pipe_v_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      rec_q    <= rec_d;
    end
  end

  assign sram_a    = addr_q;
  assign sram_wen  = 1'b1;
  assign busy      = busy_q;
  assign done      = done_q;
  assign obj_valid = valid_q;
  assign obj_last  = last_q;
  assign obj_label = rec_q.label;
  assign obj_area  = rec_q.area;
  assign obj_rmin  = rec_q.rmin;
  assign obj_rmax  = rec_q.rmax;
  assign obj_cmin  = rec_q.cmin;
  assign obj_cmax  = rec_q.cmax;
  assign obj_count = tbl_cnt;
  assign overflow  = tbl_ovf;

endmodule
